shiftreg_seq: RTL and testbench

SHIFTREG_SEQ -- requirements
Module: shiftreg_seq

---
 rtl/shiftreg_seq_if.sv | 27 ++
 rtl/shiftreg_seq.sv | 127 ++++++++++++
 tb/tb_shiftreg_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/shiftreg_seq_if.sv
// Byte-in / shift-register-control bundle for shiftreg_seq.
// The master side feeds bytes and timing; the slave side drives the external 8-bit shift register.
interface shiftreg_seq_if;
    logic [7:0] in_data;
    logic       in_dir;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] div;
    logic [3:0] gap;
    logic       abort;
    logic       sr_sload;
    logic       sr_en;
    logic       sr_dir;
    logic [7:0] sr_data;
    logic       busy;
    logic       done;

    modport master (
        output in_data, in_dir, in_valid, div, gap, abort,
        input  in_ready, sr_sload, sr_en, sr_dir, sr_data, busy, done
    );

    modport slave (
        input  in_data, in_dir, in_valid, div, gap, abort,
        output in_ready, sr_sload, sr_en, sr_dir, sr_data, busy, done
    );
endinterface

// File: rtl/shiftreg_seq.sv
// Sequencer that loads a byte into an external 8-bit shift register and clocks it out
// one bit every DIV+1 cycles, followed by an optional idle gap.
module shiftreg_seq (
    input  logic           clk,
    input  logic           rst_n,
    shiftreg_seq_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP} state_e;

    state_e     state_q,    state_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic [7:0] per_cnt_q,  per_cnt_d;
    logic [3:0] gap_cnt_q,  gap_cnt_d;
    logic [7:0] div_q,      div_d;
    logic [3:0] gap_q,      gap_d;
    logic [7:0] sr_data_q,  sr_data_d;
    logic       sr_dir_q,   sr_dir_d;
    logic       sr_en_q,    sr_en_d;
    logic       sr_sload_q, sr_sload_d;
    logic       busy_q,     busy_d;
    logic       done_q,     done_d;
    logic       in_ready_q, in_ready_d;

    always_comb begin
        // NOTE: every _d starts from its hold value so no path through the case infers a latch.
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        per_cnt_d = per_cnt_q;
        gap_cnt_d = gap_cnt_q;
        div_d     = div_q;
        gap_d     = gap_q;
        sr_data_d = sr_data_q;
        sr_dir_d  = sr_dir_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q && !bus.abort) begin
                    state_d   = ST_LOAD;
                    sr_data_d = bus.in_data;
                    sr_dir_d  = bus.in_dir;
                    div_d     = bus.div;
                    gap_d     = bus.gap;
                end
            end
            ST_LOAD: begin
                state_d   = ST_SHIFT;
                bit_cnt_d = 3'd0;
                per_cnt_d = div_q;
            end
            ST_SHIFT: begin
                if (per_cnt_q != 8'd0) begin
                    per_cnt_d = per_cnt_q - 8'd1;
                end else if (bit_cnt_q != 3'd7) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    per_cnt_d = div_q;
                end else begin
                    done_d = 1'b1;
                    if (gap_q != 4'd0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = gap_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 4'd1) state_d = ST_IDLE;
                else                   gap_cnt_d = gap_cnt_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end

        // NOTE: outputs are decoded from the next state so the registered copies line up with the state they describe.
        sr_sload_d = (state_d == ST_LOAD);
        sr_en_d    = (state_d == ST_LOAD) ||
                     ((state_d == ST_SHIFT) && (per_cnt_d == 8'd0) && (bit_cnt_d != 3'd7));
        busy_d     = (state_d != ST_IDLE);
        in_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            per_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            div_q      <= '0;
            gap_q      <= '0;
            sr_data_q  <= '0;
            sr_dir_q   <= 1'b0;
            sr_en_q    <= 1'b0;
            sr_sload_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the pre-edge values.
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            per_cnt_q  <= per_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            div_q      <= div_d;
            gap_q      <= gap_d;
            sr_data_q  <= sr_data_d;
            sr_dir_q   <= sr_dir_d;
            sr_en_q    <= sr_en_d;
            sr_sload_q <= sr_sload_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.sr_sload = sr_sload_q;
    assign bus.sr_en    = sr_en_q;
    assign bus.sr_dir   = sr_dir_q;
    assign bus.sr_data  = sr_data_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_shiftreg_seq.sv
// Self-checking bench for shiftreg_seq: per-cycle expectations derived from frame offsets,
// with a behavioural model of the downstream shift register producing Q.
`timescale 1ns/1ps
module tb_shiftreg_seq;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    shiftreg_seq_if bus ();

    shiftreg_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Downstream 8-bit register obeying the load/shift/hold contract.
    bit [7:0] sreg = 8'h00;
    logic     q;
    always @(posedge clk) begin
        if (bus.sr_en) begin
            if (bus.sr_sload)    sreg <= bus.sr_data;
            else if (bus.sr_dir) sreg <= {sreg[6:0], 1'b0};
            else                 sreg <= {1'b0, sreg[7:1]};
        end
    end
    assign q = bus.sr_dir ? sreg[7] : sreg[0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_ctl(input string tag, input logic b, input logic r,
                             input logic e, input logic s, input logic d);
        check({tag, ".busy"},     32'(bus.busy),     32'(b));
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(r));
        check({tag, ".sr_en"},    32'(bus.sr_en),    32'(e));
        check({tag, ".sr_sload"}, 32'(bus.sr_sload), 32'(s));
        check({tag, ".done"},     32'(bus.done),     32'(d));
    endtask

    // Runs one frame starting at a negedge; returns at the negedge where the block is ready again.
    // kill_at >= 0 aborts (or resets, if kill_rst) during cycle kill_at counted from the LOAD cycle.
    task automatic frame(input logic [7:0] data, input logic dir, input logic [7:0] dv,
                         input logic [3:0] gp, input bit hold, input bit scramble,
                         input int kill_at, input bit kill_rst);
        int  p, len, gl, s, k, en_seen;
        bit  ok;
        logic exp_en, exp_q;
        p   = int'(dv) + 1;
        len = 1 + 8 * p;
        gl  = int'(gp);
        bus.in_data  = data;
        bus.in_dir   = dir;
        bus.div      = dv;
        bus.gap      = gp;
        bus.in_valid = 1'b1;
        bus.abort    = 1'b0;
        ok = 1'b0;
        for (int w = 0; w < 20; w++) begin
            if (bus.in_ready === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        en_seen = 0;
        for (int t = 0; t < 5000; t++) begin
            if (t == 0) begin
                check_ctl("load", 1, 0, 1, 1, 0);
                check("load.sr_data", 32'(bus.sr_data), 32'(data));
                check("load.sr_dir",  32'(bus.sr_dir),  32'(dir));
                if (!hold) bus.in_valid = 1'b0;
            end else if (t < len) begin
                s = t - 1;
                k = s / p;
                exp_en = (s % p == p - 1) && (k < 7);
                exp_q  = dir ? data[7 - k] : data[k];
                check_ctl($sformatf("shift t=%0d", t), 1, 0, exp_en, 0, 0);
                check($sformatf("q t=%0d bit=%0d", t, k), 32'(q), 32'(exp_q));
                if (bus.sr_en === 1'b1) en_seen++;
            end else if (t == len) begin
                check_ctl("done", gl != 0, gl == 0, 0, 0, 1);
                check("en_pulses", 32'(en_seen), 32'd7);
            end else if (t < len + gl) begin
                check_ctl($sformatf("gap t=%0d", t), 1, 0, 0, 0, 0);
            end else begin
                check_ctl("post_gap", 0, 1, 0, 0, 0);
            end
            if (t >= len + gl) return;
            if (t == kill_at) begin
                if (kill_rst) begin
                    rst_n = 1'b0;
                    #1;
                    check_ctl("rst_async", 0, 0, 0, 0, 0);
                    check("rst_async.sr_data", 32'(bus.sr_data), 32'd0);
                    check("rst_async.sr_dir",  32'(bus.sr_dir),  32'd0);
                    @(negedge clk);
                    check_ctl("rst_held", 0, 0, 0, 0, 0);
                    rst_n = 1'b1;
                    #1;
                    check("rst_release.in_ready", 32'(bus.in_ready), 32'd0);
                    @(negedge clk);
                    check("rst_first_edge.in_ready", 32'(bus.in_ready), 32'd1);
                    check("rst_first_edge.busy",     32'(bus.busy),     32'd0);
                end else begin
                    bus.abort = 1'b1;
                    @(negedge clk);
                    bus.abort = 1'b0;
                    check_ctl("abort", 0, 1, 0, 0, 0);
                end
                return;
            end
            if (scramble) begin
                bus.in_data = 8'($urandom);
                bus.in_dir  = 1'($urandom);
                bus.div     = 8'($urandom);
                bus.gap     = 4'($urandom);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dv, gp, kill;
        bus.in_data  = 8'h00;
        bus.in_dir   = 1'b0;
        bus.in_valid = 1'b0;
        bus.div      = 8'h00;
        bus.gap      = 4'h0;
        bus.abort    = 1'b0;
        repeat (2) @(negedge clk);
        check_ctl("por", 0, 0, 0, 0, 0);
        check("por.sr_data", 32'(bus.sr_data), 32'd0);
        check("por.sr_dir",  32'(bus.sr_dir),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("por_first_edge.in_ready", 32'(bus.in_ready), 32'd1);

        // MSB-first 0xF5 at full rate, then a slower period.
        frame(8'hF5, 1'b1, 8'd0, 4'd0, 0, 0, -1, 0);
        frame(8'hA3, 1'b1, 8'd3, 4'd0, 0, 0, -1, 0);

        // Back-to-back with a 2-cycle gap and IN_VALID held across the frame.
        frame(8'($urandom), 1'($urandom), 8'd1, 4'd2, 1, 1, -1, 0);
        frame(8'($urandom), 1'($urandom), 8'd0, 4'd0, 0, 0, -1, 0);

        // Abort inside bit period 3, then an immediate new byte.
        frame(8'h5C, 1'b1, 8'd2, 4'd0, 0, 0, 11, 0);
        frame(8'($urandom), 1'b0, 8'd0, 4'd1, 0, 0, -1, 0);

        // Abort while idle blocks that cycle's acceptance.
        bus.in_data  = 8'h3C;
        bus.in_valid = 1'b1;
        bus.abort    = 1'b1;
        @(negedge clk);
        check_ctl("idle_abort", 0, 1, 0, 0, 0);
        bus.abort = 1'b0;
        frame(8'h3C, 1'b1, 8'd1, 4'd0, 0, 0, -1, 0);

        // LSB-first 0xF5 with DIV/GAP/data scrambled while busy.
        frame(8'hF5, 1'b0, 8'd2, 4'd1, 0, 1, -1, 0);

        // Reset in the middle of SHIFT.
        frame(8'($urandom), 1'b1, 8'd3, 4'd1, 0, 0, 10, 1);

        // Extremes of DIV and GAP.
        frame(8'($urandom), 1'($urandom), 8'd255, 4'd15, 0, 1, -1, 0);

        for (int i = 0; i < 16; i++) begin
            dv   = $urandom_range(4);
            gp   = $urandom_range(3);
            kill = ($urandom_range(5) == 0) ? 1 + $urandom_range(8 * (dv + 1) - 1) : -1;
            frame(8'($urandom), 1'($urandom), 8'(dv), 4'(gp),
                  (i < 15) && ($urandom_range(1) == 1), $urandom_range(1) == 1, kill, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
